oam_dma_master: RTL and testbench

- Bus initiator that performs the sprite (OAM) DMA transfer.
- Snoops CPU writes for the trigger register ($4014). On a hit, it stalls the CPU and takes the data bus.
- Copies LENGTH bytes from CPU page {page,8'h00} into the PPU OAM data port ($2004), one read/write pair per byte.
- Sits beside the CPU as a second bus master. It drives the same address/data/write signals that SRAM and other responders decode.

---
 rtl/oam_dma_master.sv | 133 +++++++++++++
 tb/tb_oam_dma_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_master.sv
// oam_dma_master
//   Sprite (OAM) DMA bus initiator. It snoops CPU writes for the trigger
//   register. On a hit, it stalls the CPU and copies LENGTH bytes from CPU page
//   {page,8'h00} to the PPU OAM data port. Each byte takes one read/write pair.
//
// Ports
//   clock      in   system clock, all state on posedge
//   reset      in   asynchronous, active-high
//   cpu_A      in   [15:0] snooped CPU address
//   cpu_D      in   [7:0]  snooped CPU write data (page number on trigger)
//   cpu_write  in   CPU write strobe
//   D_in       in   [7:0]  read data from the addressed responder
//   halt       out  CPU stall
//   drive      out  this block owns the shared bus
//   A          out  [15:0] bus address (0 when not driving)
//   D_out      out  [7:0]  bus write data (0 when not driving)
//   write      out  bus write strobe
//   busy       out  transfer in progress
//   done       out  one-cycle pulse after the last byte is written
module oam_dma_master #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] TARGET_ADDR  = 16'h2004,
  parameter int          LENGTH       = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_A,
  input  logic [7:0]  cpu_D,
  input  logic        cpu_write,
  input  logic [7:0]  D_in,
  output logic        halt,
  output logic        drive,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        write,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  logic [2:0] state_q, state_d;
  logic       parity_q, parity_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] latch_q, latch_d;
  logic       done_q, done_d;
  logic       trigger_hit;

  assign trigger_hit = cpu_write && (cpu_A == TRIGGER_ADDR);

  always_comb begin
    state_d  = state_q;
    // Free-running get/put phase of the CPU. HALT uses it to decide
    // whether one extra alignment cycle is needed before the first read.
    parity_d = ~parity_q;
    idx_d    = idx_q;
    page_d   = page_q;
    latch_d  = latch_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger_hit) begin
          page_d  = cpu_D;
          idx_d   = 8'd0;
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        // Responder data is valid at the edge that ends the READ cycle.
        latch_d = D_in;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          // idx is 8 bits wide. It never carries into the page byte.
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      idx_q    <= 8'd0;
      page_q   <= 8'd0;
      latch_q  <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      latch_q  <= latch_d;
      done_q   <= done_d;
    end
  end

  // Outputs decode from registered state only. This keeps cpu_* off every
  // output path.
  assign halt  = (state_q != S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign drive = (state_q == S_READ) || (state_q == S_WRITE);
  assign write = (state_q == S_WRITE);
  assign done  = done_q;

  always_comb begin
    A     = 16'h0000;
    D_out = 8'h00;
    if (state_q == S_READ) begin
      A = {page_q, idx_q};
    end else if (state_q == S_WRITE) begin
      A     = TARGET_ADDR;
      D_out = latch_q;
    end
  end

endmodule

// File: tb/tb_oam_dma_master.sv
module tb_oam_dma_master;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] TGT  = 16'h2004;

  typedef struct packed {
    logic        halt;
    logic        drive;
    logic        write;
    logic        busy;
    logic        done;
    logic [15:0] a;
    logic [7:0]  d;
  } obs_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic        exp_busy;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_a     [2];
  logic [7:0]  cpu_d     [2];
  logic        cpu_write [2];
  logic [7:0]  mem [65536];
  logic        par_g = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  // Global view of the parity used for trigger timing (read at negedges only).
  always @(posedge clock or posedge reset) begin
    if (reset) par_g <= 1'b0;
    else       par_g <= ~par_g;
  end

  function automatic obs_t rec(logic h, logic dr, logic w, logic b, logic dn,
                               logic [15:0] aa, logic [7:0] dd);
    obs_t r;
    r.halt = h; r.drive = dr; r.write = w; r.busy = b; r.done = dn;
    r.a = aa; r.d = dd;
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int LEN = (gi == 0) ? 256 : 4;
    logic        halt, drive, write, busy, done;
    logic [15:0] a;
    logic [7:0]  d_out, d_in;
    obs_t        act;
    obs_t        cur;
    obs_t        exp_q[$];
    logic        par;
    logic [7:0]  pg;
    int          halt_run, last_run, done_cnt;

    assign d_in = mem[a];
    assign act  = {halt, drive, write, busy, done, a, d_out};

    oam_dma_master #(.TRIGGER_ADDR(TRIG), .TARGET_ADDR(TGT), .LENGTH(LEN)) dut (
      .clock(clock), .reset(reset),
      .cpu_A(cpu_a[gi]), .cpu_D(cpu_d[gi]), .cpu_write(cpu_write[gi]),
      .D_in(d_in), .halt(halt), .drive(drive), .A(a), .D_out(d_out),
      .write(write), .busy(busy), .done(done));

    // Reference: a trigger seen while idle expands into the full bus trace
    // of the transfer. That trace is one HALT cycle, an optional ALIGN cycle
    // on odd parity, LEN read/write pairs and then a done cycle.
    always @(posedge clock or posedge reset) begin
      if (reset) begin
        exp_q.delete();
        cur = '0;
        par = 1'b0;
      end else begin
        par = ~par;
        if (!cur.busy && cpu_write[gi] && cpu_a[gi] == TRIG) begin
          pg = cpu_d[gi];
          exp_q.push_back(rec(1, 0, 0, 1, 0, 16'h0, 8'h0));
          if (par) exp_q.push_back(rec(1, 0, 0, 1, 0, 16'h0, 8'h0));
          for (int k = 0; k < LEN; k++) begin
            exp_q.push_back(rec(1, 1, 0, 1, 0, {pg, 8'(k)}, 8'h0));
            exp_q.push_back(rec(1, 1, 1, 1, 0, TGT, mem[{pg, 8'(k)}]));
          end
          exp_q.push_back(rec(0, 0, 0, 0, 1, 16'h0, 8'h0));
        end
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      end
    end

    initial begin
      halt_run = 0; last_run = 0; done_cnt = 0;
    end

    always @(negedge clock) begin
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL g%0d bus_cycle t=%0t: got h%0b dr%0b w%0b b%0b dn%0b A=%h D=%h, want h%0b dr%0b w%0b b%0b dn%0b A=%h D=%h",
                 gi, $time, act.halt, act.drive, act.write, act.busy, act.done, act.a, act.d,
                 cur.halt, cur.drive, cur.write, cur.busy, cur.done, cur.a, cur.d);
      end
      if (reset) halt_run = 0;
      else if (halt) halt_run++;
      else if (halt_run > 0) begin
        last_run = halt_run;
        halt_run = 0;
      end
      if (done) done_cnt++;
    end
  end

  function automatic obs_t get_obs(int i);
    return (i == 0) ? g[0].act : g[1].act;
  endfunction
  function automatic int get_last_run(int i);
    return (i == 0) ? g[0].last_run : g[1].last_run;
  endfunction
  function automatic int get_done_cnt(int i);
    return (i == 0) ? g[0].done_cnt : g[1].done_cnt;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(int i, string nm);
    obs_t o;
    o = get_obs(i);
    chk(nm, 32'(o), 32'h0);
  endtask

  // want_odd: 1 = parity 1 in HALT, 0 = parity 0 in HALT, -1 = don't care.
  task automatic trig(int i, logic [7:0] pg, int want_odd);
    @(negedge clock);
    if (want_odd >= 0) while (par_g == want_odd[0]) @(negedge clock);
    cpu_a[i] = TRIG; cpu_d[i] = pg; cpu_write[i] = 1'b1;
    @(negedge clock);
    cpu_write[i] = 1'b0; cpu_a[i] = 16'h0; cpu_d[i] = 8'h0;
  endtask

  task automatic wait_idle(int i, int budget, string nm);
    int n;
    obs_t o;
    n = 0;
    o = get_obs(i);
    while (o.busy && n < budget) begin
      @(negedge clock);
      o = get_obs(i);
      n++;
    end
    if (n >= budget) chk({nm, "_timeout"}, 32'(n), 32'(budget - 1));
    @(negedge clock);
  endtask

  task automatic run_xfer(int i, logic [7:0] pg, int want_odd, string nm, int exp_run);
    int dc0;
    obs_t o;
    dc0 = get_done_cnt(i);
    trig(i, pg, want_odd);
    o = get_obs(i);
    chk({nm, "_halt_1cyc"}, 32'(o.halt), 32'd1);
    wait_idle(i, 2000, nm);
    chk({nm, "_halt_cycles"}, 32'(get_last_run(i)), 32'(exp_run));
    chk({nm, "_done_pulses"}, 32'(get_done_cnt(i) - dc0), 32'd1);
  endtask

  task automatic wait_write_count(int i, int cnt, string nm);
    int seen, n;
    obs_t o;
    seen = 0; n = 0;
    while (seen < cnt && n < 3000) begin
      @(negedge clock);
      o = get_obs(i);
      if (o.write && o.a == TGT) seen++;
      n++;
    end
    if (n >= 3000) chk({nm, "_timeout"}, 32'(seen), 32'(cnt));
  endtask

  vec_t vecs[6];

  initial begin
    obs_t o;
    int dc0, n;

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 2; i++) begin
      cpu_a[i] = 16'h0; cpu_d[i] = 8'h0; cpu_write[i] = 1'b0;
    end

    // Reset values and the first cycle after release.
    #1;
    chk_zero(0, "reset_held_g0");
    chk_zero(1, "reset_held_g1");
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk_zero(0, "post_reset_g0");
    chk_zero(1, "post_reset_g1");

    // Even- and odd-aligned full transfers.
    run_xfer(0, 8'h02, 0, "even", 513);
    run_xfer(0, 8'h02, 1, "odd", 514);

    // A second trigger during byte 100 is ignored.
    trig(0, 8'h02, 0);
    wait_write_count(0, 100, "busy_trig");
    cpu_a[0] = TRIG; cpu_d[0] = 8'h07; cpu_write[0] = 1'b1;
    @(negedge clock);
    cpu_write[0] = 1'b0; cpu_a[0] = 16'h0;
    wait_idle(0, 2000, "busy_trig");
    chk("busy_trig_halt_cycles", 32'(get_last_run(0)), 32'd513);

    // Table: snooped cycles in IDLE. Only a write to the trigger starts a transfer.
    vecs[0] = '{16'h4015, 8'h02, 1'b1, 1'b0};
    vecs[1] = '{16'h4014, 8'h02, 1'b0, 1'b0};
    vecs[2] = '{16'h4013, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{16'h0014, 8'h02, 1'b1, 1'b0};
    vecs[4] = '{16'hC014, 8'h02, 1'b1, 1'b0};
    vecs[5] = '{16'h4014, 8'h05, 1'b1, 1'b1};
    for (int v = 0; v < 6; v++) begin
      @(negedge clock);
      cpu_a[0] = vecs[v].a; cpu_d[0] = vecs[v].d; cpu_write[0] = vecs[v].w;
      @(negedge clock);
      cpu_write[0] = 1'b0; cpu_a[0] = 16'h0;
      o = get_obs(0);
      chk($sformatf("idle_vec%0d_busy", v), 32'(o.busy), 32'(vecs[v].exp_busy));
    end
    wait_idle(0, 2000, "vec_xfer");

    // Abort with reset in the WRITE of idx 0x40.
    trig(0, 8'h10, -1);
    wait_write_count(0, 65, "abort");
    dc0 = get_done_cnt(0);
    #2 reset = 1'b1;
    #1;
    chk_zero(0, "abort_released");
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_no_done", 32'(get_done_cnt(0) - dc0), 32'd0);
    trig(0, 8'h03, -1);
    n = 0;
    o = get_obs(0);
    while (!o.drive && n < 10) begin
      @(negedge clock);
      o = get_obs(0);
      n++;
    end
    chk("abort_first_read_addr", 32'(o.a), 32'h0300);
    wait_idle(0, 2000, "after_abort");
    chk("after_abort_done", 32'(get_done_cnt(0) - dc0), 32'd1);

    // Page $FF, LENGTH 4, back-to-back trigger during the done cycle.
    trig(1, 8'hFF, -1);
    n = 0;
    o = get_obs(1);
    while (!o.done && n < 20) begin
      @(negedge clock);
      o = get_obs(1);
      n++;
    end
    chk("ff_done_seen", 32'(o.done), 32'd1);
    cpu_a[1] = TRIG; cpu_d[1] = 8'hFE; cpu_write[1] = 1'b1;
    @(negedge clock);
    cpu_write[1] = 1'b0; cpu_a[1] = 16'h0;
    o = get_obs(1);
    chk("b2b_halt_next", 32'(o.halt), 32'd1);
    chk("b2b_done_one_cycle", 32'(o.done), 32'd0);
    wait_idle(1, 100, "b2b");

    // Randomized traffic on both instances, checked cycle by cycle by the model.
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 3))
          0, 1:    cpu_a[i] = TRIG;
          2:       cpu_a[i] = TRIG + 16'd1;
          default: cpu_a[i] = 16'($urandom);
        endcase
        cpu_d[i]     = 8'($urandom);
        cpu_write[i] = ($urandom_range(0, 7) == 0);
      end
    end
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      cpu_write[i] = 1'b0; cpu_a[i] = 16'h0;
    end
    wait_idle(0, 2000, "rand_g0");
    wait_idle(1, 100, "rand_g1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
